// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared FSM type, digit limit and
// gate-length helpers for the freq_meter_bcd counter.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GATE,
    LATCH,
    HOLD
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int gate_cyc(
    input int clk_fre,
    input int gate_ms
  );
    return (clk_fre / 1000) * gate_ms;
  endfunction

  // Gate shortened by 10^rng, never below one cycle.
  function automatic int gate_div(
    input int cyc,
    input int rng
  );
    int d;
    d = cyc;
    for (int i = 0; i < rng; i++) d = d / 10;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one decimal digit of the working
// count cascade with clear, carry-in and hold.
module bcd_digit_cnt
  import freq_meas_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_d;
  logic [3:0] digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc && !sat) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0
                                     : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= 4'd0;
    else        digit_q <= digit_d;
  end

  assign digit     = digit_q;
  assign carry_out = (digit_q == BCD_MAX);

endmodule

// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: gated BCD frequency counter with hold.
// Optional auto-ranging gate: define FREQ_AUTORANGE_EN.
module freq_meter_bcd
  import freq_meas_pkg::*;
#(
  parameter int CLK_FRE     = 12_000_000,
  parameter int DIGITS      = 4,
  parameter int GATE_MS     = 1000,
  parameter int HOLD_GATES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  input  logic                en,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                valid,
  output logic                ovf,
  output logic                busy,
  output logic [1:0]          range
);

  localparam int GATE_CYC = gate_cyc(CLK_FRE, GATE_MS);
  localparam int CW =
    (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int HW =
    (HOLD_GATES > 1) ? $clog2(HOLD_GATES) : 1;
  localparam logic [CW-1:0] LIM0 =
    CW'(gate_div(GATE_CYC, 0) - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(GATE_CYC - 1);
  localparam logic [HW-1:0] HG_LAST =
    HW'((HOLD_GATES > 0) ? HOLD_GATES - 1 : 0);

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   sig_rise;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] gate_last;
  logic [HW-1:0] hg_q, hg_d;
  logic          gate_end;
  logic          hold_end;

  logic [4*DIGITS-1:0] work;
  logic [DIGITS-1:0]   carry;
  logic                count_en;
  logic                sat;
  logic                wovf_q, wovf_d;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  // Synchroniser plus one delay flop for rise detection.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  assign sig_rise = sync_q[SYNC_STAGES-1] & ~dly_q;

  assign gate_end = (state_q == GATE) &&
                    (cnt_q == gate_last);
  assign hold_end = (state_q == HOLD) &&
                    (cnt_q == HOLD_LAST) &&
                    (hg_q == HG_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = ARM;
      ARM:     state_d = GATE;
      GATE:    if (gate_end) state_d = LATCH;
      LATCH:   state_d = (HOLD_GATES == 0) ? ARM : HOLD;
      HOLD:    if (hold_end) state_d = ARM;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    hg_d  = hg_q;
    unique case (state_q)
      GATE: begin
        cnt_d = gate_end ? '0 : cnt_q + 1'b1;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          hg_d  = hg_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        hg_d  = '0;
      end
    endcase
  end

  assign count_en = (state_q == GATE) && sig_rise;
  assign sat      = count_en && (&carry);

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic inc_k;
    if (k == 0) begin : g_lsd
      assign inc_k = count_en;
    end else begin : g_up
      assign inc_k = count_en & (&carry[k-1:0]);
    end
    bcd_digit_cnt u_dig (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (state_q == ARM),
      .inc       (inc_k),
      .sat       (sat),
      .digit     (work[4*k +: 4]),
      .carry_out (carry[k])
    );
  end

  always_comb begin
    wovf_d = wovf_q;
    if (state_q == ARM) wovf_d = 1'b0;
    else if (sat)       wovf_d = 1'b1;
  end

  always_comb begin
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (state_q == LATCH) begin
      disp_d  = work;
      ovf_d   = wovf_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      dly_q   <= 1'b0;
      cnt_q   <= '0;
      hg_q    <= '0;
      wovf_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      hg_q    <= hg_d;
      wovf_q  <= wovf_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

`ifdef FREQ_AUTORANGE_EN
  localparam logic [CW-1:0] LIM1 =
    CW'(gate_div(GATE_CYC, 1) - 1);
  localparam logic [CW-1:0] LIM2 =
    CW'(gate_div(GATE_CYC, 2) - 1);
  localparam logic [CW-1:0] LIM3 =
    CW'(gate_div(GATE_CYC, 3) - 1);

  // mrange_q steers the running gate; range_q reports
  // the exponent that belongs to the latched result.
  logic [1:0] mrange_q, mrange_d;
  logic [1:0] range_q, range_d;

  always_comb begin
    gate_last = LIM0;
    unique case (mrange_q)
      2'd1:    gate_last = LIM1;
      2'd2:    gate_last = LIM2;
      2'd3:    gate_last = LIM3;
      default: gate_last = LIM0;
    endcase
  end

  always_comb begin
    mrange_d = mrange_q;
    range_d  = range_q;
    if (state_q == LATCH) begin
      range_d = mrange_q;
      if (wovf_q && mrange_q != 2'd3) begin
        mrange_d = mrange_q + 2'd1;
      end else if (work[4*DIGITS-1 -: 4] == 4'd0 &&
                   mrange_q != 2'd0) begin
        mrange_d = mrange_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrange_q <= 2'd0;
      range_q  <= 2'd0;
    end else begin
      mrange_q <= mrange_d;
      range_q  <= range_d;
    end
  end

  assign range = range_q;
`else
  assign gate_last = LIM0;
  assign range     = 2'd0;
`endif

  always_comb begin
    busy = (state_q == ARM) || (state_q == GATE);
  end

  assign bcd_out = disp_q;
  assign ovf     = ovf_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// tb_freq_meter_bcd: randomized self-checking bench
// for freq_meter_bcd (4-digit and 2-digit instances).
module tb_freq_meter_bcd;

  localparam int G  = 1000;
  localparam int HG = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        en = 1'b0;
  logic [15:0] bcd0;
  logic [7:0]  bcd1;
  logic        valid0, ovf0, busy0;
  logic        valid1, ovf1, busy1;
  logic [1:0]  range0, range1;

  freq_meter_bcd #(
    .CLK_FRE(10_000), .DIGITS(4), .GATE_MS(100),
    .HOLD_GATES(HG), .SYNC_STAGES(2)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .bcd_out(bcd0), .valid(valid0), .ovf(ovf0),
    .busy(busy0), .range(range0)
  );

  freq_meter_bcd #(
    .CLK_FRE(10_000), .DIGITS(2), .GATE_MS(100),
    .HOLD_GATES(HG), .SYNC_STAGES(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .bcd_out(bcd1), .valid(valid1), .ovf(ovf1),
    .busy(busy1), .range(range1)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Stimulus: 0 low, 1 periodic, 2 random, 3 pulse list.
  int cyc = 0;
  int mode = 0;
  int period = 20;
  int ph = 0;
  int pulse[$];
  bit rise_log [0:65535];

  always @(posedge clk) begin : drive
    logic v;
    cyc++;
    #1;
    v = 1'b0;
    if (mode == 1) v = (ph % period) < (period / 2);
    else if (mode == 2) v = 1'($urandom_range(0, 1));
    else if (mode == 3) begin
      foreach (pulse[i]) if (pulse[i] == cyc) v = 1'b1;
    end
    ph++;
    if (v && !sig_in && cyc < 65536) rise_log[cyc] = 1'b1;
    sig_in = v;
  end

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [1:0]  rng;
    int          at;
  } snap_t;

  snap_t q0[$];
  snap_t q1[$];

  always @(negedge clk) begin
    if (valid0 === 1'b1)
      q0.push_back('{bcd0, ovf0, range0, cyc});
    if (valid1 === 1'b1)
      q1.push_back('{{8'h00, bcd1}, ovf1, range1, cyc});
  end

  // Reference model state per instance.
  int          mr[2];
  logic [15:0] last_bcd[2];

  function automatic int pw10(input int e);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int digs(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int glen(input int i);
    int d;
    d = G / pw10(mr[i]);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int count_rises(input int a, input int n);
    int s;
    s = 0;
    for (int k = a; k < a + n; k++)
      if (k >= 0 && k < 65536 && rise_log[k]) s++;
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Rises driven after posedge e .. e+len-1 land in the gate.
  task automatic expect_result(
    input  int    i,
    input  int    e,
    input  string tag,
    output int    gl
  );
    snap_t s;
    int    n, cap, w, shown, qs;
    gl = glen(i);
    w  = 0;
    qs = (i == 0) ? q0.size() : q1.size();
    while (qs == 0 && w < 4 * G) begin
      @(negedge clk);
      w++;
      qs = (i == 0) ? q0.size() : q1.size();
    end
    if (qs == 0) begin
      chk($sformatf("%s_i%0d_timeout", tag, i), 0, 1);
      return;
    end
    s     = (i == 0) ? q0.pop_front() : q1.pop_front();
    n     = count_rises(e, gl);
    cap   = pw10(digs(i)) - 1;
    shown = (n > cap) ? cap : n;
    chk($sformatf("%s_i%0d_bcd", tag, i), s.bcd, to_bcd(shown));
    chk($sformatf("%s_i%0d_ovf", tag, i), s.ovf, n > cap);
    chk($sformatf("%s_i%0d_rng", tag, i), s.rng, mr[i]);
    chk($sformatf("%s_i%0d_at", tag, i), s.at, e + 3 + gl);
    last_bcd[i] = s.bcd;
`ifdef FREQ_AUTORANGE_EN
    if (n > cap && mr[i] < 3) mr[i]++;
    else if (shown < pw10(digs(i) - 1) && mr[i] > 0) mr[i]--;
`endif
  endtask

  task automatic measure(input string tag);
    int e, gl;
    @(negedge clk);
    e  = cyc;
    en = 1'b1;
    expect_result(0, e, tag, gl);
    expect_result(1, e, tag, gl);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_periodic(input int p);
    @(negedge clk);
    mode   = 1;
    period = p;
    ph     = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int e, gl0, gl1, e0, e1;
    mr = '{0, 0};
    last_bcd = '{16'h0, 16'h0};

    repeat (3) @(negedge clk);
    chk("rst_bcd0", bcd0, 0);
    chk("rst_bcd1", bcd1, 0);
    chk("rst_valid", {valid0, valid1}, 0);
    chk("rst_ovf", {ovf0, ovf1}, 0);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_range", {range0, range1}, 0);
    rst_n = 1'b1;

    set_periodic(20);
    measure("p20");
    chk("p20_lit", last_bcd[0], 16'h0050);

    // Abort part-way through the gate.
    @(negedge clk);
    e  = cyc;
    en = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_busy_hi", busy0, 1);
    while (cyc < e + 600) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy0", busy0, 0);
    chk("abort_busy1", busy1, 0);
    repeat (1100) @(negedge clk);
    chk("abort_nv0", q0.size(), 0);
    chk("abort_nv1", q1.size(), 0);
    chk("abort_keep0", bcd0, last_bcd[0]);
    chk("abort_keep1", bcd1, last_bcd[1][7:0]);
    measure("reen");

    // Rises on the first and last gate cycles only.
    @(negedge clk);
    e = cyc + 5;
    pulse = '{e - 2, e, e + G - 1, e + G + 1};
    mode = 3;
    while (cyc < e) @(negedge clk);
    en = 1'b1;
    expect_result(0, e, "edge", gl0);
    expect_result(1, e, "edge", gl1);
    @(negedge clk);
    en = 1'b0;
    chk("edge_lit", last_bcd[0], 16'h0002);

    // Back-to-back with one gate of hold.
    set_periodic(20);
    @(negedge clk);
    e0 = cyc;
    e1 = cyc;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_result(0, e0, $sformatf("hold%0d", k), gl0);
      expect_result(1, e1, $sformatf("hold%0d", k), gl1);
      e0 += gl0 + HG * G + 2;
      e1 += gl1 + HG * G + 2;
    end
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a gate.
    @(negedge clk);
    en = 1'b1;
    repeat (400) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_bcd", {bcd0, bcd1}, 0);
    chk("mrst_flags", {valid0, ovf0, busy0, range0}, 0);
    chk("mrst_flags1", {valid1, ovf1, busy1, range1}, 0);
    en = 1'b0;
    q0.delete();
    q1.delete();
    mr = '{0, 0};
    last_bcd = '{16'h0, 16'h0};
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    measure("post_rst");

    set_periodic(2);
    measure("p2");
    set_periodic(40);
    measure("p40");

    for (int k = 0; k < 2; k++) begin
      set_periodic(int'($urandom_range(2, 60)));
      measure($sformatf("rper%0d", k));
    end
    @(negedge clk);
    mode = 2;
    for (int k = 0; k < 3; k++) measure($sformatf("rnd%0d", k));

    repeat (5) @(negedge clk);
    chk("end_q0", q0.size(), 0);
    chk("end_q1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
